// File: rtl/cr_prefix_pf_sched.sv
// rtl/cr_prefix_pf_sched.sv - round-robin dispatch of frame prefix lookups to N_ENG engines
// Results are collected in dispatch order into the prefix-number FIFO.
module cr_prefix_pf_sched #(
  parameter int N_ENG = 4,
  parameter int PF_W  = 9,
  parameter int PTR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PTR_W:0]          cfg_eng_num,
  input  logic                    frm_valid,
  output logic                    frm_ready,
  output logic [N_ENG-1:0]        eng_start,
  input  logic [N_ENG-1:0]        eng_done,
  input  logic [N_ENG*PF_W-1:0]   eng_data,
  input  logic                    pf_full,
  input  logic                    pf_afull,
  output logic                    pf_wr,
  output logic [PF_W-1:0]         pf_wdata,
  output logic [PTR_W:0]          outstanding,
  output logic                    proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } slot_e;

  localparam logic [PTR_W:0]   N_ENG_W = (PTR_W+1)'(N_ENG);
  localparam logic [PTR_W:0]   ONE_W   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

  slot_e             slot_q [N_ENG];
  slot_e             slot_d [N_ENG];
  logic [PF_W-1:0]   res_q  [N_ENG];
  logic [PF_W-1:0]   res_d  [N_ENG];
  logic [PTR_W-1:0]  dsp_ptr_q, dsp_ptr_d;
  logic [PTR_W-1:0]  col_ptr_q, col_ptr_d;
  logic [PTR_W:0]    active_num_q, active_num_d;
  logic [PTR_W:0]    out_q, out_d;
  logic              init_q, init_d;
  logic [N_ENG-1:0]  eng_start_q, eng_start_d;
  logic              pf_wr_q, pf_wr_d;
  logic [PF_W-1:0]   pf_wdata_q, pf_wdata_d;
  logic              proto_err_q, proto_err_d;

  logic [PTR_W:0]    cfg_num;
  logic [PTR_W:0]    act_num;
  logic [PTR_W:0]    act_m1;
  slot_e             dsp_slot;
  slot_e             col_slot;
  logic [PF_W-1:0]   col_res;
  logic              accept;
  logic              drain;

  always_comb begin
    cfg_num = (cfg_eng_num == '0 || cfg_eng_num > N_ENG_W) ? N_ENG_W : cfg_eng_num;
    // init_q stands in for "active_num loads the configured count at reset"
    act_num = init_q ? cfg_num : active_num_q;
    act_m1  = act_num - ONE_W;

    dsp_slot = S_IDLE;
    col_slot = S_IDLE;
    col_res  = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (dsp_ptr_q == PTR_W'(i)) dsp_slot = slot_q[i];
      if (col_ptr_q == PTR_W'(i)) begin
        col_slot = slot_q[i];
        col_res  = res_q[i];
      end
    end

    frm_ready = (dsp_slot == S_IDLE) && (out_q < act_num);
    accept    = frm_valid && frm_ready;
    drain     = (col_slot == S_DONE) && !pf_full && !(pf_afull && pf_wr_q);

    for (int i = 0; i < N_ENG; i++) begin
      slot_d[i] = slot_q[i];
      res_d[i]  = res_q[i];
    end
    eng_start_d  = '0;
    proto_err_d  = proto_err_q;
    pf_wr_d      = drain;
    pf_wdata_d   = drain ? col_res : '0;
    dsp_ptr_d    = dsp_ptr_q;
    col_ptr_d    = col_ptr_q;
    active_num_d = act_num;
    init_d       = 1'b0;
    out_d        = out_q;

    for (int i = 0; i < N_ENG; i++) begin
      if (eng_done[i]) begin
        if (slot_q[i] == S_BUSY) begin
          slot_d[i] = S_DONE;
          res_d[i]  = eng_data[i*PF_W +: PF_W];
        end else begin
          proto_err_d = 1'b1;
        end
      end
      if (accept && dsp_ptr_q == PTR_W'(i)) begin
        slot_d[i]      = S_BUSY;
        eng_start_d[i] = 1'b1;
      end
      if (drain && col_ptr_q == PTR_W'(i)) slot_d[i] = S_IDLE;
    end

    if (accept) dsp_ptr_d = ({1'b0, dsp_ptr_q} == act_m1) ? '0 : dsp_ptr_q + ONE_P;
    if (drain)  col_ptr_d = ({1'b0, col_ptr_q} == act_m1) ? '0 : col_ptr_q + ONE_P;

    case ({accept, drain})
      2'b10:   out_d = out_q + ONE_W;
      2'b01:   out_d = out_q - ONE_W;
      default: out_d = out_q;
    endcase

    // Engine count only changes with the pipe empty, so both pointers restart together
    if (out_q == '0 && !accept) begin
      active_num_d = cfg_num;
      dsp_ptr_d    = '0;
      col_ptr_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENG; i++) begin
        slot_q[i] <= S_IDLE;
        res_q[i]  <= '0;
      end
      dsp_ptr_q    <= '0;
      col_ptr_q    <= '0;
      active_num_q <= N_ENG_W;
      out_q        <= '0;
      init_q       <= 1'b1;
      eng_start_q  <= '0;
      pf_wr_q      <= 1'b0;
      pf_wdata_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENG; i++) begin
        slot_q[i] <= slot_d[i];
        res_q[i]  <= res_d[i];
      end
      dsp_ptr_q    <= dsp_ptr_d;
      col_ptr_q    <= col_ptr_d;
      active_num_q <= active_num_d;
      out_q        <= out_d;
      init_q       <= init_d;
      eng_start_q  <= eng_start_d;
      pf_wr_q      <= pf_wr_d;
      pf_wdata_q   <= pf_wdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign eng_start   = eng_start_q;
  assign pf_wr       = pf_wr_q;
  assign pf_wdata    = pf_wdata_q;
  assign outstanding = out_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_cr_prefix_pf_sched.sv
// tb/tb_cr_prefix_pf_sched.sv - scoreboard bench for cr_prefix_pf_sched
// Emulates the engines and predicts dispatch, drain and error behaviour from the scheduling rules.
module tb_cr_prefix_pf_sched;
  localparam int N_ENG = 4;
  localparam int PF_W  = 9;
  localparam int PTR_W = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [PTR_W:0]        cfg_eng_num = (PTR_W+1)'(4);
  logic                  frm_valid = 1'b0;
  logic                  frm_ready;
  logic [N_ENG-1:0]      eng_start;
  logic [N_ENG-1:0]      eng_done = '0;
  logic [N_ENG*PF_W-1:0] eng_data = '0;
  logic                  pf_full = 1'b0;
  logic                  pf_afull = 1'b0;
  logic                  pf_wr;
  logic [PF_W-1:0]       pf_wdata;
  logic [PTR_W:0]        outstanding;
  logic                  proto_err;

  always #5 clk = ~clk;

  cr_prefix_pf_sched #(.N_ENG(N_ENG), .PF_W(PF_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .cfg_eng_num(cfg_eng_num),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .eng_start(eng_start), .eng_done(eng_done), .eng_data(eng_data),
    .pf_full(pf_full), .pf_afull(pf_afull),
    .pf_wr(pf_wr), .pf_wdata(pf_wdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int plan_q[$];
  int st  [N_ENG];   // engine slot: 0 free, 1 working, 2 result waiting
  int cnt [N_ENG];
  int eng_res [N_ENG];
  int m_out, m_dsp, m_col, m_act;
  bit m_proto, m_init, auto_eng;

  function automatic int cfg_san(int c);
    return (c < 1 || c > N_ENG) ? N_ENG : c;
  endfunction

  function automatic int nxt(int p, int act);
    return (p == act - 1) ? 0 : p + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every FIFO write must carry the oldest dispatched result
  always @(negedge clk) begin
    if (!rst && pf_wr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pf_wdata: write 0x%0h with no result expected at %0t", pf_wdata, $time);
      end else begin
        chk("pf_wdata", int'(pf_wdata), exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    bit acc, dr, rl, exp_rdy;
    int e_start, done_m, cfg_now;
    #1;
    cfg_now = int'(cfg_eng_num);
    if (m_init) m_act = cfg_san(cfg_now);
    exp_rdy = (st[m_dsp] == 0) && (m_out < m_act);
    chk("frm_ready", int'(frm_ready), int'(exp_rdy));
    acc     = frm_valid && exp_rdy;
    dr      = (st[m_col] == 2) && !pf_full && !(pf_afull && pf_wr);
    rl      = (m_out == 0) && !acc;
    done_m  = int'(eng_done);
    e_start = m_dsp;
    @(negedge clk);
    m_init = 1'b0;
    chk("pf_wr", int'(pf_wr), int'(dr));
    if (dr) begin
      st[m_col] = 0;
      m_out--;
      m_col = nxt(m_col, m_act);
    end
    for (int i = 0; i < N_ENG; i++) begin
      if (done_m[i]) begin
        if (st[i] == 1) st[i] = 2;
        else m_proto = 1'b1;
      end
    end
    if (acc) begin
      st[e_start] = 1;
      m_out++;
      m_dsp = nxt(m_dsp, m_act);
      eng_res[e_start] = (plan_q.size() > 0) ? plan_q.pop_front() : int'($urandom_range(0, 511));
      exp_q.push_back(eng_res[e_start]);
      cnt[e_start] = int'($urandom_range(2, 7));
    end
    if (rl) begin
      m_act = cfg_san(cfg_now);
      m_dsp = 0;
      m_col = 0;
    end
    chk("eng_start", int'(eng_start), acc ? (1 << e_start) : 0);
    chk("outstanding", int'(outstanding), m_out);
    chk("proto_err", int'(proto_err), int'(m_proto));
    eng_done = '0;
    if (auto_eng) begin
      for (int i = 0; i < N_ENG; i++) begin
        if (st[i] == 1 && cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            eng_done[i] = 1'b1;
            eng_data[i*PF_W +: PF_W] = PF_W'(eng_res[i]);
          end
        end
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic fire(input int mask);
    for (int i = 0; i < N_ENG; i++) begin
      if (mask[i]) begin
        eng_done[i] = 1'b1;
        eng_data[i*PF_W +: PF_W] = PF_W'(eng_res[i]);
      end
    end
    tick();
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (m_out > 0 && k < 300) begin
      tick();
      k++;
    end
    if (m_out > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: outstanding %0d expected 0 after %0d cycles", m_out, k);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    frm_valid = 1'b0;
    eng_done  = '0;
    pf_full   = 1'b0;
    pf_afull  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_eng_start", int'(eng_start), 0);
    chk("rst_pf_wr", int'(pf_wr), 0);
    chk("rst_pf_wdata", int'(pf_wdata), 0);
    chk("rst_outstanding", int'(outstanding), 0);
    chk("rst_proto_err", int'(proto_err), 0);
    for (int i = 0; i < N_ENG; i++) begin
      st[i]  = 0;
      cnt[i] = 0;
    end
    m_out   = 0;
    m_dsp   = 0;
    m_col   = 0;
    m_proto = 1'b0;
    m_init  = 1'b1;
    exp_q.delete();
    plan_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    auto_eng = 1'b0;
    m_act    = N_ENG;
    do_reset();
    run(2);

    // single frame, result 0x005 two cycles after done
    plan_q.push_back('h005);
    frm_valid = 1'b1; tick(); frm_valid = 1'b0; tick();
    fire(1); run(4);

    // four frames completing out of order, written back in order
    plan_q.push_back('h010); plan_q.push_back('h011);
    plan_q.push_back('h012); plan_q.push_back('h013);
    frm_valid = 1'b1; run(4); frm_valid = 1'b0; tick();
    fire(8); fire(2); fire(1); fire(4); run(6);

    // fifth frame stalls until the first drain, then goes to engine 0
    frm_valid = 1'b1; run(6);
    fire(1); run(4);
    frm_valid = 1'b0; tick();
    fire(2); fire(4); fire(8); run(3); fire(1); run(6);

    // FIFO full back-pressure, then almost-full gap
    pf_full = 1'b1;
    frm_valid = 1'b1; run(2); frm_valid = 1'b0; tick();
    fire(3); run(10);
    pf_full = 1'b0; run(5);
    pf_afull = 1'b1;
    frm_valid = 1'b1; run(2); frm_valid = 1'b0; tick();
    fire(3); run(6);
    pf_afull = 1'b0;

    // stray done on an idle engine, then an error-flagged result
    eng_res[2] = 'h0AA;
    fire(4); tick();
    plan_q.push_back('h1A3);
    frm_valid = 1'b1; tick(); frm_valid = 1'b0; tick();
    fire(1); run(4);

    // engine count change waits for the pipe to empty
    frm_valid = 1'b1; run(3); frm_valid = 1'b0;
    cfg_eng_num = (PTR_W+1)'(2); run(3);
    fire(1); fire(2); fire(4); run(6);
    auto_eng = 1'b1;
    frm_valid = 1'b1; run(12); frm_valid = 1'b0;
    wait_drain(); run(2);

    // randomized traffic with a mid-run reset
    for (int it = 0; it < 3000; it++) begin
      frm_valid = ($urandom % 4) != 0;
      pf_full   = ($urandom % 5) == 0;
      pf_afull  = ($urandom % 4) == 0;
      if (($urandom % 200) == 0) cfg_eng_num = (PTR_W+1)'($urandom_range(0, 9));
      if (it == 1500) do_reset();
      tick();
    end
    frm_valid = 1'b0;
    pf_full   = 1'b0;
    pf_afull  = 1'b0;
    wait_drain();
    run(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
